// File: rtl/my_stack_8.sv
// my_stack_8: LIFO controller in front of an 8 x 16 RAM with a combinational read port.
// Turns push/pop/clear into RAM accesses, tracks the depth, returns popped words
// one cycle after the pop, and keeps sticky overflow/underflow flags.
module my_stack_8 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [3:0]       count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic [2:0]       ram_addr,
  output logic [WIDTH-1:0] ram_in,
  output logic             ram_load,
  input  logic [WIDTH-1:0] ram_out
);

  localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

  // One decoded command per cycle, already resolved for priority
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_SWAP,
    OP_CLEAR,
    OP_RESET
  } op_t;

  op_t        op;
  logic [2:0] top_addr;

  // The top word lives one below the depth; when empty this wraps to 7,
  // which is harmless because nothing is written or returned from there.
  assign top_addr = count[2:0] - 3'd1;
  assign empty    = (count == 4'd0);
  assign full     = (count == DEPTH_CNT);
  assign ram_in   = in;

  // Resolve reset > clear > push/pop into a single command
  always_comb begin
    op = OP_IDLE;
    if (reset)
      op = OP_RESET;
    else if (clear)
      op = OP_CLEAR;
    else if (push && pop)
      op = OP_SWAP;
    else if (push)
      op = OP_PUSH;
    else if (pop)
      op = OP_POP;
  end

  // RAM port: present the top by default, redirect the address only for writes
  always_comb begin
    ram_addr = top_addr;
    ram_load = 1'b0;
    case (op)
      OP_PUSH: begin
        if (!full) begin
          ram_addr = count[2:0];
          ram_load = 1'b1;
        end
      end
      OP_SWAP: begin
        ram_load = 1'b1;
        ram_addr = empty ? 3'd0 : top_addr;
      end
      default: ;
    endcase
  end

  // Depth, returned word and sticky flags; a replace reads the old top
  // because the RAM only takes the new word at this same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 4'd0;
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (op)
        OP_CLEAR: begin
          count     <= 4'd0;
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
        OP_PUSH: begin
          if (full)
            overflow <= 1'b1;
          else
            count <= count + 4'd1;
        end
        OP_POP: begin
          if (empty) begin
            underflow <= 1'b1;
          end else begin
            out       <= ram_out;
            out_valid <= 1'b1;
            count     <= count - 4'd1;
          end
        end
        OP_SWAP: begin
          if (empty) begin
            count     <= 4'd1;
            underflow <= 1'b1;
          end else begin
            out       <= ram_out;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_my_stack_8.sv
// tb_my_stack_8: directed vector table, a full-stack replace sequence and a
// randomized run against a queue-based stack model, with an 8 x 16 RAM attached.
module tb_my_stack_8;

  logic        clk;
  logic        reset;
  logic        push;
  logic        pop;
  logic        clear;
  logic [15:0] in;
  logic [15:0] out;
  logic        out_valid;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;
  logic [2:0]  ram_addr;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  logic [15:0] ram_mem [8] = '{default: 16'h0000};

  int checks = 0;
  int errors = 0;

  my_stack_8 dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .ram_addr  (ram_addr),
    .ram_in    (ram_in),
    .ram_load  (ram_load),
    .ram_out   (ram_out)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached RAM: combinational read, write at the rising edge
  assign ram_out = ram_mem[ram_addr];
  always @(posedge clk) begin
    if (ram_load)
      ram_mem[ram_addr] <= ram_in;
  end

  typedef struct {
    logic        rst;
    logic        clr;
    logic        psh;
    logic        pp;
    logic [15:0] din;
    logic        exp_load;
    logic [2:0]  exp_addr;
    logic [3:0]  exp_count;
    logic [15:0] exp_out;
    logic        exp_valid;
    logic        exp_ovf;
    logic        exp_udf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic rst, input logic clr, input logic psh,
                                  input logic pp, input logic [15:0] din,
                                  input logic exp_load, input logic [2:0] exp_addr,
                                  input logic [3:0] exp_count, input logic [15:0] exp_out,
                                  input logic exp_valid, input logic exp_ovf,
                                  input logic exp_udf);
    vec_t v;
    v.rst = rst; v.clr = clr; v.psh = psh; v.pp = pp; v.din = din;
    v.exp_load = exp_load; v.exp_addr = exp_addr; v.exp_count = exp_count;
    v.exp_out = exp_out; v.exp_valid = exp_valid; v.exp_ovf = exp_ovf;
    v.exp_udf = exp_udf;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after an edge and let the combinational outputs settle
  task automatic applyStimulus(input logic rst, input logic clr, input logic psh,
                               input logic pp, input logic [15:0] din);
    reset = rst;
    clear = clr;
    push  = psh;
    pop   = pp;
    in    = din;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRegistered(input string tag, input logic [3:0] e_count,
                                 input logic [15:0] e_out, input logic e_valid,
                                 input logic e_ovf, input logic e_udf);
    checkOutput({tag, " count"}, 16'(count), 16'(e_count));
    checkOutput({tag, " out"}, out, e_out);
    checkOutput({tag, " out_valid"}, 16'(out_valid), 16'(e_valid));
    checkOutput({tag, " overflow"}, 16'(overflow), 16'(e_ovf));
    checkOutput({tag, " underflow"}, 16'(underflow), 16'(e_udf));
    checkOutput({tag, " empty"}, 16'(empty), 16'(e_count == 4'd0));
    checkOutput({tag, " full"}, 16'(full), 16'(e_count == 4'd8));
  endtask

  // Behavioural reference for the random phase
  logic [15:0] m_q[$];
  logic [15:0] m_out;
  logic        m_valid;
  logic        m_ovf;
  logic        m_udf;

  initial begin
    vec_t v;
    string tag;
    int bias;
    int size;
    logic r, c, ps, pp;
    logic [15:0] d;
    logic e_load;
    logic [2:0] e_addr;

    // ---------------- reset state ----------------
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("reset ram_load", 16'(ram_load), 16'd0);
    checkOutput("reset ram_addr", 16'(ram_addr), 16'd7);
    checkRegistered("reset", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // ---------------- directed table ----------------
    // push 0x1111, 0x2222, 0x3333
    add_vec(0,0,1,0,16'h1111, 1,3'd0, 4'd1,16'h0000,0,0,0);
    add_vec(0,0,1,0,16'h2222, 1,3'd1, 4'd2,16'h0000,0,0,0);
    add_vec(0,0,1,0,16'h3333, 1,3'd2, 4'd3,16'h0000,0,0,0);
    // pop them back in reverse order
    add_vec(0,0,0,1,16'h0000, 0,3'd2, 4'd2,16'h3333,1,0,0);
    add_vec(0,0,0,1,16'h0000, 0,3'd1, 4'd1,16'h2222,1,0,0);
    add_vec(0,0,0,1,16'h0000, 0,3'd0, 4'd0,16'h1111,1,0,0);
    add_vec(0,0,0,0,16'h0000, 0,3'd7, 4'd0,16'h1111,0,0,0);
    // fill to 8, then a rejected 9th push
    for (int i = 0; i < 8; i++)
      add_vec(0,0,1,0,16'(i), 1,3'(i), 4'(i + 1),16'h1111,0,0,0);
    add_vec(0,0,1,0,16'h0008, 0,3'd7, 4'd8,16'h1111,0,1,0);
    add_vec(0,0,0,0,16'h0000, 0,3'd7, 4'd8,16'h1111,0,1,0);
    // clear, pop while empty, clear again
    add_vec(0,1,0,0,16'h0000, 0,3'd7, 4'd0,16'h1111,0,0,0);
    add_vec(0,0,0,1,16'h0000, 0,3'd7, 4'd0,16'h1111,0,0,1);
    add_vec(0,0,0,0,16'h0000, 0,3'd7, 4'd0,16'h1111,0,0,1);
    add_vec(0,1,0,0,16'h0000, 0,3'd7, 4'd0,16'h1111,0,0,0);
    // replace top of [AAAA, BBBB] with CCCC, then drain
    add_vec(0,0,1,0,16'hAAAA, 1,3'd0, 4'd1,16'h1111,0,0,0);
    add_vec(0,0,1,0,16'hBBBB, 1,3'd1, 4'd2,16'h1111,0,0,0);
    add_vec(0,0,1,1,16'hCCCC, 1,3'd1, 4'd2,16'hBBBB,1,0,0);
    add_vec(0,0,0,1,16'h0000, 0,3'd1, 4'd1,16'hCCCC,1,0,0);
    add_vec(0,0,0,1,16'h0000, 0,3'd0, 4'd0,16'hAAAA,1,0,0);
    // push+pop while empty performs the push and flags underflow
    add_vec(0,0,1,1,16'h1234, 1,3'd0, 4'd1,16'hAAAA,0,0,1);
    add_vec(0,0,0,1,16'h0000, 0,3'd0, 4'd0,16'h1234,1,0,1);
    add_vec(0,1,0,0,16'h0000, 0,3'd7, 4'd0,16'h1234,0,0,0);
    // count=5, clear+push, then reset during a push
    for (int i = 0; i < 5; i++)
      add_vec(0,0,1,0,16'h5000 + 16'(i), 1,3'(i), 4'(i + 1),16'h1234,0,0,0);
    add_vec(0,1,1,0,16'h9999, 0,3'd4, 4'd0,16'h1234,0,0,0);
    add_vec(1,0,1,0,16'h7777, 0,3'd7, 4'd0,16'h0000,0,0,0);

    foreach (vecs[i]) begin
      v = vecs[i];
      tag = $sformatf("row%0d", i);
      applyStimulus(v.rst, v.clr, v.psh, v.pp, v.din);
      checkOutput({tag, " ram_load"}, 16'(ram_load), 16'(v.exp_load));
      checkOutput({tag, " ram_addr"}, 16'(ram_addr), 16'(v.exp_addr));
      checkOutput({tag, " ram_in"}, ram_in, v.din);
      advance();
      checkRegistered(tag, v.exp_count, v.exp_out, v.exp_valid, v.exp_ovf, v.exp_udf);
    end

    // The suppressed writes must have left the RAM untouched
    checkOutput("mem4 after clear+push", ram_mem[4], 16'h5004);
    checkOutput("mem7 after reset+push", ram_mem[7], 16'h0007);
    checkOutput("mem0 after reset+push", ram_mem[0], 16'h5000);

    // ---------------- replace top while full ----------------
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
      advance();
    end
    checkOutput("full count", 16'(count), 16'd8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    checkOutput("full swap ram_load", 16'(ram_load), 16'd1);
    checkOutput("full swap ram_addr", 16'(ram_addr), 16'd7);
    advance();
    checkRegistered("full swap", 4'd8, 16'h0107, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    advance();
    checkRegistered("pop after full swap", 4'd7, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // ---------------- randomized run against the model ----------------
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    advance();
    m_q.delete();
    m_out = 16'h0000;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    bias = 70;
    for (int n = 0; n < 1500; n++) begin
      if (n % 150 == 0)
        bias = (bias == 70) ? 30 : 70;
      r  = ($urandom_range(0, 63) == 0);
      c  = ($urandom_range(0, 31) == 0);
      ps = ($urandom_range(0, 99) < bias);
      pp = ($urandom_range(0, 99) < 100 - bias);
      d  = 16'($urandom);
      size = m_q.size();

      e_load = !r && !c && ps && (pp || size < 8);
      if (e_load)
        e_addr = (pp && size > 0) ? 3'(size - 1) : (pp ? 3'd0 : 3'(size));
      else
        e_addr = 3'(size + 7);

      tag = $sformatf("rand%0d", n);
      applyStimulus(r, c, ps, pp, d);
      checkOutput({tag, " ram_load"}, 16'(ram_load), 16'(e_load));
      if (e_load || size > 0)
        checkOutput({tag, " ram_addr"}, 16'(ram_addr), 16'(e_addr));
      advance();

      if (r) begin
        m_q.delete();
        m_out = 16'h0000;
        m_valid = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else if (c) begin
        m_q.delete();
        m_valid = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else begin
        m_valid = 1'b0;
        if (ps && pp) begin
          if (size == 0) begin
            m_q.push_back(d);
            m_udf = 1'b1;
          end else begin
            m_out = m_q[$];
            m_q[$] = d;
            m_valid = 1'b1;
          end
        end else if (ps) begin
          if (size == 8)
            m_ovf = 1'b1;
          else
            m_q.push_back(d);
        end else if (pp) begin
          if (size == 0) begin
            m_udf = 1'b1;
          end else begin
            m_out = m_q.pop_back();
            m_valid = 1'b1;
          end
        end
      end
      checkRegistered(tag, 4'(m_q.size()), m_out, m_valid, m_ovf, m_udf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
